// File: rtl/m_nibble_serial_adder.sv
// Nibble-serial adder: sequences a W-bit addition through an external 4-bit
// ripple adder, one nibble per clock, least-significant nibble first.
module m_nibble_serial_adder #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES,
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] S,
    output logic         Cout,
    output logic [3:0]   ADD_A,
    output logic [3:0]   ADD_B,
    output logic         ADD_CIN,
    input  logic [3:0]   ADD_S,
    input  logic         ADD_COUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    s_q, s_d;
    logic            cout_q, cout_d;

    // Bit offset of the nibble currently being summed.
    logic [IDXW+1:0] nib_base;
    assign nib_base = {idx_q, 2'b00};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                end
            end
            RUN: begin
                s_d[nib_base +: 4] = ADD_S;
                carry_d            = ADD_COUT;
                if (idx_q == LAST_IDX) begin
                    cout_d = ADD_COUT;
                    idx_d  = '0;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        ADD_A   = 4'h0;
        ADD_B   = 4'h0;
        ADD_CIN = 1'b0;
        if (state_q == RUN) begin
            ADD_A   = a_q[nib_base +: 4];
            ADD_B   = b_q[nib_base +: 4];
            ADD_CIN = carry_q;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_m_nibble_serial_adder.sv
// Directed and random checks of m_nibble_serial_adder with a behavioural
// 4-bit ripple adder attached to its adder port.
module tb_m_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A, B;
    logic        Cin;
    logic        busy, done;
    logic [15:0] S;
    logic        Cout;
    logic [3:0]  ADD_A, ADD_B;
    logic        ADD_CIN;
    logic [3:0]  ADD_S;
    logic        ADD_COUT;

    int n_checks = 0;
    int n_errors = 0;

    m_nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .Cin     (Cin),
        .busy    (busy),
        .done    (done),
        .S       (S),
        .Cout    (Cout),
        .ADD_A   (ADD_A),
        .ADD_B   (ADD_B),
        .ADD_CIN (ADD_CIN),
        .ADD_S   (ADD_S),
        .ADD_COUT(ADD_COUT)
    );

    always #5 clk = ~clk;

    // External 4-bit adder, purely combinational.
    assign {ADD_COUT, ADD_S} = {1'b0, ADD_A} + {1'b0, ADD_B} + {4'b0, ADD_CIN};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; with disturb set, inputs are scrambled and start is
    // re-pulsed during RUN and DONE, which must have no effect.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input bit disturb);
        logic [16:0] ref_sum;
        logic [31:0] mask, carry_chain;
        int          n;
        ref_sum = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        A = a; B = b; Cin = cin; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            check("busy_op", busy, 1);
            check("done_op", done, (i == 5));
            if (i <= 4) begin
                n           = i - 1;
                mask        = (32'h1 << (4 * n)) - 1;
                carry_chain = (({16'b0, a} & mask) + ({16'b0, b} & mask) + {31'b0, cin}) >> (4 * n);
                check("add_a_run", ADD_A, ({16'b0, a} >> (4 * n)) & 32'hF);
                check("add_b_run", ADD_B, ({16'b0, b} >> (4 * n)) & 32'hF);
                check("add_cin_run", ADD_CIN, carry_chain & 32'h1);
                if (i == 1) check("s_cleared", S, 0);
            end else begin
                check("add_a_done", ADD_A, 0);
                check("add_cin_done", ADD_CIN, 0);
                check("s_done", S, ref_sum[15:0]);
                check("cout_done", Cout, ref_sum[16]);
            end
            if (disturb && (i == 2 || i == 5)) begin
                A = ~a; B = 16'hFFFF; Cin = 1'b1; start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("busy_idle", busy, 0);
        check("done_idle", done, 0);
        check("s_final", S, ref_sum[15:0]);
        check("cout_final", Cout, ref_sum[16]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s", S, 0);
        check("rst_cout", Cout, 0);
        check("rst_add_a", ADD_A, 0);
        check("rst_add_cin", ADD_CIN, 0);
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);  // 0x5555, Cout 0
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);  // full ripple
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);  // 0x8000
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);  // 0xFFFF, Cout 1

        // Result holds in IDLE while inputs wander.
        A = 16'hAAAA; B = 16'h5555; Cin = 1'b1;
        tick();
        tick();
        check("hold_s", S, 16'hFFFF);
        check("hold_cout", Cout, 1);
        check("hold_busy", busy, 0);

        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b1);  // 0x1000, disturbance ignored

        // Reset in RUN cycle 2 aborts without a done pulse.
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_abort_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_s", S, 0);
        check("abort_cout", Cout, 0);
        check("abort_add_cin", ADD_CIN, 0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0);  // 0x0002, accepted right away

        for (int k = 0; k < 1000; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
